uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 113 +++++++++++
 tb/tb_uart_tx.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with a valid/ready byte input
//
// Parameters:
//   cycles_per_bit  clk cycles per serial bit (2..65535), default 434
// Ports:
//   clk     sole clock, rising edge
//   rst_n   asynchronous active-low reset
//   tx      serial line output, idle high, registered
//   tready  high when a byte can be accepted (IDLE only)
//   tvalid  byte on tdata is valid
//   tdata   byte to transmit, sent LSB first

module uart_tx #(
    parameter int cycles_per_bit = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       tx,
    output logic       tready,
    input  logic       tvalid,
    input  logic [7:0] tdata
);

    localparam int CNT_W = $clog2(cycles_per_bit);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(cycles_per_bit - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_done;

    assign bit_done = (bit_cnt == CNT_LAST);

    // tx is updated on the same edge that changes state, so the line level
    // always matches the bit being sent without any combinational output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            tready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    bit_idx <= '0;
                    if (tvalid && tready) begin
                        // Start bit goes out on the accepting edge itself.
                        shreg  <= tdata;
                        tready <= 1'b0;
                        tx     <= 1'b0;
                        state  <= START;
                    end else begin
                        // Also raises tready on the first edge after reset.
                        tready <= 1'b1;
                        tx     <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[bit_idx + 3'd1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        // One IDLE cycle follows before the next byte can be
                        // accepted, giving a single idle-high cycle between frames.
                        bit_cnt <= '0;
                        tready  <= 1'b1;
                        tx      <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx
module tb_uart_tx;

    localparam int CPB  = 434;
    localparam int CPB2 = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tx, tready, tvalid;
    logic [7:0] tdata;
    logic       tx2, tready2, tvalid2;
    logic [7:0] tdata2;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;

    uart_tx #(.cycles_per_bit(CPB)) u_dut (
        .clk(clk), .rst_n(rst_n), .tx(tx), .tready(tready),
        .tvalid(tvalid), .tdata(tdata)
    );

    uart_tx #(.cycles_per_bit(CPB2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tx(tx2), .tready(tready2),
        .tvalid(tvalid2), .tdata(tdata2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Presents one byte, then follows the whole frame, sampling mid-bit.
    task automatic frame(input logic [7:0] b, input logic [7:0] b_mid, input logic v_mid,
                         output logic [9:0] bits, output int low, output logic tx0,
                         output logic end_tx, output logic end_rdy);
        int n;
        int guard;
        guard = 0;
        @(negedge clk);
        while (tready !== 1'b1 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (tready !== 1'b1) begin
            errors++;
            $display("FAIL frame_ready_timeout: tready=%b required 1", tready);
        end
        tdata  = b;
        tvalid = 1'b1;
        @(posedge clk);
        #1;
        tx0    = tx;
        tdata  = b_mid;
        tvalid = v_mid;
        n      = 0;
        low    = 0;
        bits   = '1;
        forever begin
            if ((n % CPB) == CPB / 2 && n < 10 * CPB) bits[n / CPB] = tx;
            if (tready === 1'b0) low++;
            if (n == 10 * CPB) break;
            @(posedge clk);
            #1;
            n++;
        end
        end_tx  = tx;
        end_rdy = tready;
        tvalid  = 1'b0;
    endtask

    // Independent receiver: waits for a start edge, then samples mid-bit.
    task automatic rx_byte(output logic [9:0] bits, output int t0);
        int n;
        int guard;
        guard = 0;
        bits  = '1;
        t0    = -1;
        @(posedge clk);
        #1;
        while (tx !== 1'b0 && guard < 20000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL rx_start_timeout: tx=%b required 0", tx);
            return;
        end
        t0 = cyc;
        n  = 0;
        forever begin
            if ((n % CPB) == CPB / 2) bits[n / CPB] = tx;
            if (n == 9 * CPB + CPB / 2) break;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset;
        int bad;
        bad    = 0;
        tvalid = 1'b0;
        tdata  = 8'h00;
        tvalid2 = 1'b0;
        tdata2  = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: tx=%b tready=%b required tx=1 tready=0", tx, tready);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tready !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_hold: bad samples=%0d required 0", bad);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (tready !== 1'b1 || tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: tready=%b tx=%b required 1 1", tready, tx);
        end
    endtask

    task automatic test_single;
        logic [9:0] bits;
        int         low;
        logic       tx0, etx, erdy;
        frame(8'hA5, 8'hA5, 1'b0, bits, low, tx0, etx, erdy);
        checks++;
        if (tx0 !== 1'b0) begin
            errors++;
            $display("FAIL single_start_latency: tx=%b required 0", tx0);
        end
        checks++;
        if (bits !== 10'b1_1010_0101_0) begin
            errors++;
            $display("FAIL single_bits: got %b required %b", bits, 10'b1_1010_0101_0);
        end
        checks++;
        if (low !== 4340) begin
            errors++;
            $display("FAIL single_tready_low: got %0d required 4340", low);
        end
        checks++;
        if (etx !== 1'b1 || erdy !== 1'b1) begin
            errors++;
            $display("FAIL single_end: tx=%b tready=%b required 1 1", etx, erdy);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] vec [7];
        int         t0s [7];
        vec = '{8'h3C, 8'hC3, 8'h01, 8'h80, 8'h55, 8'hAA, 8'h7E};
        fork
            begin
                int guard;
                @(negedge clk);
                tdata  = vec[0];
                tvalid = 1'b1;
                for (int i = 0; i < 7; i++) begin
                    guard = 0;
                    while (tready !== 1'b1 && guard < 20000) begin
                        @(negedge clk);
                        guard++;
                    end
                    @(posedge clk);
                    #1;
                    if (i < 6) tdata = vec[i + 1];
                    else tvalid = 1'b0;
                    @(negedge clk);
                end
            end
            begin
                logic [9:0] bits;
                int         t0;
                for (int i = 0; i < 7; i++) begin
                    rx_byte(bits, t0);
                    t0s[i] = t0;
                    checks++;
                    if (bits !== {1'b1, vec[i], 1'b0}) begin
                        errors++;
                        $display("FAIL b2b_byte%0d: got %b required %b", i, bits, {1'b1, vec[i], 1'b0});
                    end
                    if (i > 0) begin
                        checks++;
                        if (t0s[i] - t0s[i - 1] !== 10 * CPB + 1) begin
                            errors++;
                            $display("FAIL b2b_gap%0d: got %0d required %0d", i, t0s[i] - t0s[i - 1], 10 * CPB + 1);
                        end
                    end
                end
            end
        join
        tvalid = 1'b0;
    endtask

    task automatic test_tdata_change;
        logic [9:0] bits;
        int         low;
        logic       tx0, etx, erdy;
        int         bad;
        frame(8'h00, 8'hFF, 1'b1, bits, low, tx0, etx, erdy);
        checks++;
        if (bits !== 10'b1_0000_0000_0) begin
            errors++;
            $display("FAIL tdata_change: got %b required %b", bits, 10'b1_0000_0000_0);
        end
        bad = 0;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL tdata_change_idle: low samples=%0d required 0", bad);
        end
    endtask

    task automatic test_reset_mid;
        logic [9:0] bits;
        int         low, bad;
        logic       tx0, etx, erdy;
        @(negedge clk);
        tdata  = 8'h00;
        tvalid = 1'b1;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        for (int n = 1; n <= 4 * CPB + CPB / 2; n++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pre: tx=%b required 0", tx);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || tready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abort: tx=%b tready=%b required 1 0", tx, tready);
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (tready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_release: tready=%b required 1", tready);
        end
        bad = 0;
        for (int i = 0; i < 2 * CPB; i++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL midreset_no_resume: low samples=%0d required 0", bad);
        end
        frame(8'h3C, 8'h3C, 1'b0, bits, low, tx0, etx, erdy);
        checks++;
        if (bits !== 10'b1_0011_1100_0) begin
            errors++;
            $display("FAIL midreset_after: got %b required %b", bits, 10'b1_0011_1100_0);
        end
    endtask

    task automatic test_cpb2;
        logic [9:0] bits;
        int         n;
        @(negedge clk);
        tdata2  = 8'h81;
        tvalid2 = 1'b1;
        @(posedge clk);
        #1;
        tvalid2 = 1'b0;
        bits    = '1;
        n       = 0;
        checks++;
        if (tx2 !== 1'b0) begin
            errors++;
            $display("FAIL cpb2_start: tx=%b required 0", tx2);
        end
        while (tready2 !== 1'b1 && n < 100) begin
            if ((n % CPB2) == 1 && n < 10 * CPB2) bits[n / CPB2] = tx2;
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== 20) begin
            errors++;
            $display("FAIL cpb2_length: got %0d cycles required 20", n);
        end
        checks++;
        if (bits !== 10'b1_1000_0001_0) begin
            errors++;
            $display("FAIL cpb2_bits: got %b required %b", bits, 10'b1_1000_0001_0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_tdata_change();
        test_reset_mid();
        test_cpb2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
